// File: rtl/queue_dispatcher_pkg.sv
// Shared constants for the queue dispatcher and its arbiter: default queue geometry,
// skid-buffer depth and the credit check that bounds outstanding reads.
package queue_dispatcher_pkg;

  localparam int unsigned QD_QUEUE_QUANTITY = 4;
  localparam int unsigned QD_DATA_BITS      = 8;
  localparam int unsigned QD_SKID_DEPTH     = 2;
  localparam int unsigned QD_OCC_BITS       = $clog2(QD_SKID_DEPTH + 1);
  localparam int unsigned QD_CREDIT_BITS    = QD_OCC_BITS + 1;
  localparam int unsigned QD_COUNT_BITS     = 16;

  // A new pop is allowed only if buffered + in-flight words, minus the one leaving, fit the skid.
  function automatic logic credit_ok(input logic [QD_OCC_BITS-1:0] occ,
                                     input logic                   inflight,
                                     input logic                   xfer);
    return (QD_CREDIT_BITS'(occ) + QD_CREDIT_BITS'(inflight))
         < (QD_CREDIT_BITS'(QD_SKID_DEPTH) + QD_CREDIT_BITS'(xfer));
  endfunction

endpackage

// File: rtl/dispatch_skid.sv
// Two-entry synchronous FIFO holding {queue, word} pairs between the queue read
// ports and the downstream handshake; the head register drives the outputs directly.
module dispatch_skid
  import queue_dispatcher_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [QD_OCC_BITS-1:0] occ_o
);

  localparam logic [QD_OCC_BITS-1:0] OCC_EMPTY = '0;
  localparam logic [QD_OCC_BITS-1:0] OCC_ONE   = QD_OCC_BITS'(1);
  localparam logic [QD_OCC_BITS-1:0] OCC_FULL  = QD_OCC_BITS'(QD_SKID_DEPTH);

  logic [WIDTH-1:0]       head_q, head_d;
  logic [WIDTH-1:0]       tail_q, tail_d;
  logic [QD_OCC_BITS-1:0] occ_q, occ_d;
  logic                   rd_ok, wr_ok;

  // Head is always the oldest word; a read at full promotes the tail.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    rd_ok  = rd_en_i && (occ_q != OCC_EMPTY);
    wr_ok  = wr_en_i && ((occ_q != OCC_FULL) || rd_ok);
    case (occ_q)
      OCC_EMPTY: begin
        if (wr_ok) begin
          head_d = wr_data_i;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (wr_ok && rd_ok) begin
          head_d = wr_data_i;
        end else if (wr_ok) begin
          tail_d = wr_data_i;
          occ_d  = OCC_FULL;
        end else if (rd_ok) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (rd_ok) begin
          head_d = tail_q;
          if (wr_ok) begin
            tail_d = wr_data_i;
          end else begin
            occ_d = OCC_ONE;
          end
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= OCC_EMPTY;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign rd_data_o = head_q;
  assign occ_o     = occ_q;

endmodule

// File: rtl/queue_dispatcher.sv
// Pops the arbiter-selected queue under a credit limit, captures the word one cycle
// later into a two-entry skid, and presents it downstream with a valid/ready handshake.
module queue_dispatcher
  import queue_dispatcher_pkg::*;
#(
  parameter int unsigned QUEUE_QUANTITY = QD_QUEUE_QUANTITY,
  parameter int unsigned DATA_BITS      = QD_DATA_BITS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [$clog2(QUEUE_QUANTITY)-1:0]   selector,
  input  logic                                selector_enb,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data,
  output logic [QUEUE_QUANTITY-1:0]           pop,
  output logic                                rr_enb,
  output logic [DATA_BITS-1:0]                out_data,
  output logic [$clog2(QUEUE_QUANTITY)-1:0]   out_queue,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [QD_COUNT_BITS-1:0]            dispatch_count
);

  localparam int unsigned SEL_BITS   = $clog2(QUEUE_QUANTITY);
  localparam int unsigned ENTRY_BITS = SEL_BITS + DATA_BITS;

  logic                     inflight_q, inflight_d;
  logic [SEL_BITS-1:0]      inflight_sel_q, inflight_sel_d;
  logic [QD_COUNT_BITS-1:0] count_q, count_d;
  logic [QD_OCC_BITS-1:0]   occ;
  logic [DATA_BITS-1:0]     sel_word;
  logic [ENTRY_BITS-1:0]    wr_entry;
  logic [ENTRY_BITS-1:0]    head_entry;
  logic                     xfer_c;
  logic                     credit_ok_c;

  assign xfer_c      = out_valid & out_ready;
  assign credit_ok_c = credit_ok(occ, inflight_q, xfer_c);

  // One-hot read strobe; reset overrides everything so no read escapes during reset.
  always_comb begin
    pop = '0;
    if (!rst && enb && selector_enb && credit_ok_c) begin
      pop[selector] = 1'b1;
    end
  end

  assign rr_enb = |pop;

  // Select the slice of the queue read last cycle.
  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
      if (SEL_BITS'(i) == inflight_sel_q) begin
        sel_word = fifo_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign wr_entry = {inflight_sel_q, sel_word};

  always_comb begin
    inflight_d     = rr_enb;
    inflight_sel_d = selector;
    count_d        = count_q + QD_COUNT_BITS'(xfer_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q     <= 1'b0;
      inflight_sel_q <= '0;
      count_q        <= '0;
    end else begin
      inflight_q     <= inflight_d;
      inflight_sel_q <= inflight_sel_d;
      count_q        <= count_d;
    end
  end

  dispatch_skid #(
    .WIDTH(ENTRY_BITS)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (inflight_q),
    .wr_data_i (wr_entry),
    .rd_en_i   (xfer_c),
    .rd_data_o (head_entry),
    .occ_o     (occ)
  );

  assign out_valid      = (occ != '0);
  assign out_data       = head_entry[DATA_BITS-1:0];
  assign out_queue      = head_entry[ENTRY_BITS-1 -: SEL_BITS];
  assign dispatch_count = count_q;

endmodule

// File: tb/tb_queue_dispatcher.sv
// Directed bench for queue_dispatcher: round-robin arbiter and registered-read queues
// modelled here, hand-computed expectations applied row by row.
module tb_queue_dispatcher;

  localparam int unsigned QQ = 4;
  localparam int unsigned DB = 8;
  localparam int unsigned SW = 2;

  logic           clk;
  logic           rst;
  logic           enb;
  logic [SW-1:0]  selector;
  logic           selector_enb;
  logic [QQ*DB-1:0] fifo_data;
  logic [QQ-1:0]  pop;
  logic           rr_enb;
  logic [DB-1:0]  out_data;
  logic [SW-1:0]  out_queue;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    dispatch_count;

  int vectors     = 0;
  int miscompares = 0;
  int row_id      = 0;
  int exp_count   = 0;

  logic [SW-1:0] rr_q;
  logic [7:0]    q_cnt   [QQ];
  logic [7:0]    q_rdata [QQ];

  queue_dispatcher #(
    .QUEUE_QUANTITY(QQ),
    .DATA_BITS     (DB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enb            (enb),
    .selector       (selector),
    .selector_enb   (selector_enb),
    .fifo_data      (fifo_data),
    .pop            (pop),
    .rr_enb         (rr_enb),
    .out_data       (out_data),
    .out_queue      (out_queue),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .dispatch_count (dispatch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin arbiter advanced by rr_enb.
  always @(posedge clk) begin
    if (rst) rr_q <= '0;
    else if (rr_enb) rr_q <= rr_q + 2'd1;
  end
  assign selector = rr_q;

  // Queue i yields (A0 + 11h*i) + k on its k-th pop, one cycle after the pop.
  always @(posedge clk) begin
    for (int i = 0; i < QQ; i++) begin
      if (rst) begin
        q_cnt[i]   <= 8'h00;
        q_rdata[i] <= 8'h00;
      end else if (pop[i]) begin
        q_rdata[i] <= 8'(32'hA0 + 32'h11 * i) + q_cnt[i];
        q_cnt[i]   <= q_cnt[i] + 8'h01;
      end
    end
  end

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < QQ; i++) fifo_data[i*DB +: DB] = q_rdata[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Apply one cycle's inputs, check outputs mid-cycle, then advance one clock.
  task automatic row(input logic en, input logic se, input logic rd,
                     input logic [3:0] e_pop, input logic e_v,
                     input logic [1:0] e_q, input logic [7:0] e_d);
    enb = en;
    selector_enb = se;
    out_ready = rd;
    #1;
    chk($sformatf("r%0d.pop", row_id), 32'(pop), 32'(e_pop));
    chk($sformatf("r%0d.rr_enb", row_id), 32'(rr_enb), 32'(|e_pop));
    chk($sformatf("r%0d.out_valid", row_id), 32'(out_valid), 32'(e_v));
    chk($sformatf("r%0d.count", row_id), 32'(dispatch_count), 32'(exp_count));
    if (e_v) begin
      chk($sformatf("r%0d.out_queue", row_id), 32'(out_queue), 32'(e_q));
      chk($sformatf("r%0d.out_data", row_id), 32'(out_data), 32'(e_d));
      if (rd) exp_count++;
    end
    row_id++;
    step();
  endtask

  initial begin
    rst = 1'b1;
    enb = 1'b1;
    selector_enb = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    chk("rst.pop", 32'(pop), 32'd0);
    chk("rst.rr_enb", 32'(rr_enb), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_queue", 32'(out_queue), 32'd0);
    chk("rst.count", 32'(dispatch_count), 32'd0);
    rst = 1'b0;

    // Streaming through queues 0..3 with ready held high, then select disabled, then enb low.
    row(1, 1, 1, 4'b0001, 0, 2'd0, 8'h00);
    row(1, 1, 1, 4'b0010, 0, 2'd0, 8'h00);
    row(1, 1, 1, 4'b0100, 1, 2'd0, 8'hA0);
    row(1, 1, 1, 4'b1000, 1, 2'd1, 8'hB1);
    row(1, 1, 1, 4'b0001, 1, 2'd2, 8'hC2);
    row(1, 0, 1, 4'b0000, 1, 2'd3, 8'hD3);
    row(1, 0, 1, 4'b0000, 1, 2'd0, 8'hA1);
    row(1, 0, 1, 4'b0000, 0, 2'd0, 8'h00);
    row(0, 1, 1, 4'b0000, 0, 2'd0, 8'h00);
    row(0, 1, 1, 4'b0000, 0, 2'd0, 8'h00);

    // Ready low: exactly two pops fill the skid, then release.
    row(1, 1, 0, 4'b0010, 0, 2'd0, 8'h00);
    row(1, 1, 0, 4'b0100, 0, 2'd0, 8'h00);
    row(1, 1, 0, 4'b0000, 1, 2'd1, 8'hB2);
    row(1, 1, 0, 4'b0000, 1, 2'd1, 8'hB2);
    row(1, 1, 1, 4'b1000, 1, 2'd1, 8'hB2);
    row(1, 1, 1, 4'b0001, 1, 2'd2, 8'hC3);
    row(1, 1, 1, 4'b0010, 1, 2'd3, 8'hD4);
    row(1, 0, 1, 4'b0000, 1, 2'd0, 8'hA2);
    row(1, 0, 1, 4'b0000, 1, 2'd1, 8'hB3);
    row(1, 0, 1, 4'b0000, 0, 2'd0, 8'h00);

    // Ready toggling with continuous supply.
    row(1, 1, 1, 4'b0100, 0, 2'd0, 8'h00);
    row(1, 1, 0, 4'b1000, 0, 2'd0, 8'h00);
    row(1, 1, 1, 4'b0001, 1, 2'd2, 8'hC4);
    row(1, 1, 0, 4'b0000, 1, 2'd3, 8'hD5);
    row(1, 1, 1, 4'b0010, 1, 2'd3, 8'hD5);
    row(1, 1, 0, 4'b0000, 1, 2'd0, 8'hA3);
    row(1, 1, 1, 4'b0100, 1, 2'd0, 8'hA3);
    row(1, 1, 0, 4'b0000, 1, 2'd1, 8'hB4);
    row(1, 0, 1, 4'b0000, 1, 2'd1, 8'hB4);
    row(1, 0, 1, 4'b0000, 1, 2'd2, 8'hC5);
    row(1, 0, 1, 4'b0000, 0, 2'd0, 8'h00);

    // Reset with one word buffered and one read in flight.
    row(1, 1, 0, 4'b1000, 0, 2'd0, 8'h00);
    row(1, 1, 0, 4'b0001, 0, 2'd0, 8'h00);
    rst = 1'b1;
    #1;
    chk("midrst.pop", 32'(pop), 32'd0);
    chk("midrst.rr_enb", 32'(rr_enb), 32'd0);
    chk("midrst.out_valid_pre", 32'(out_valid), 32'd1);
    step();
    rst = 1'b0;
    selector_enb = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.count", 32'(dispatch_count), 32'd0);
    chk("midrst.out_data", 32'(out_data), 32'd0);
    chk("midrst.out_queue", 32'(out_queue), 32'd0);
    step();
    #1;
    chk("midrst.stale1", 32'(out_valid), 32'd0);
    step();
    #1;
    chk("midrst.stale2", 32'(out_valid), 32'd0);

    // 65537 back-to-back transfers: counter wraps through FFFF to 1.
    enb = 1'b1;
    selector_enb = 1'b1;
    out_ready = 1'b1;
    repeat (65537) step();
    selector_enb = 1'b0;
    #1;
    chk("wrap.count_ffff", 32'(dispatch_count), 32'h0000FFFF);
    chk("wrap.pop_off", 32'(pop), 32'd0);
    step();
    step();
    #1;
    chk("wrap.out_valid", 32'(out_valid), 32'd0);
    chk("wrap.count", 32'(dispatch_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
